uart_rx_oversampled: RTL
========================

Name: uart_rx_oversampled

Overview:
- Asynchronous serial receiver (8N1, LSB first) for the FPGA side of the Raspberry Pi link.
- Contains its own fractional-accumulator tick generator running at Baud*Oversampling.
- Synchronises and filters rxd, then finds the start edge and samples each bit at its centre.
- Delivers each byte with a one-cycle valid strobe; companion to the transmit path driven by the 1x baud tick generator.

Parameters:
- ClkFrequency, 50000000, system clock in Hz.
- Baud, 460800, line bit rate.
- Oversampling, 8, ticks per bit period; must be a power of two, minimum 4.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rxd  in  1  serial input, idle high, asynchronous to clk.
- rx_data  out  8  last good byte; holds its value until the next good byte.
- data_ready  out  1  one-clk pulse when rx_data updates.
- framing_error  out  1  one-clk pulse when the stop bit samples 0.
- parity_error  out  1  one-clk pulse on parity mismatch; see Optional Feature.
- rx_busy  out  1  high from start-edge detect until return to IDLE.

Behaviour:
- Reset: one clock and one reset for the whole block; reset is asynchronous and active-low (rst_n). In reset, rx_data=0, data_ready=0, framing_error=0, parity_error=0, rx_busy=0, synchroniser and filter flops=1, accumulator=0, state=IDLE.
- Tick generator:
  - AccWidth = log2(ClkFrequency/Baud)+8.
  - Inc = round(Baud*Oversampling*2^AccWidth/ClkFrequency), computed with pre-shifting so no 32-bit intermediate overflows.
  - Acc is an (AccWidth+1)-bit register. Each clk: Acc <= Acc[AccWidth-1:0] + Inc. tick = Acc[AccWidth].
  - Free-running; never gated by the FSM.
- Input path:
  - 2-flop synchroniser on rxd.
  - On each tick, shift the synchronised bit into a 3-bit history; filtered bit = majority of the 3.
- Bit-timing counter: log2(Oversampling) bits, advances on tick only.
- FSM, all transitions on tick cycles:
  - IDLE: filtered bit = 0 → START, counter cleared, rx_busy=1.
  - START: when counter reaches Oversampling/2-1, re-check the filtered bit. If 0 → DATA, bit index=0, counter cleared. If 1 (glitch) → IDLE, no pulses.
  - DATA: every Oversampling ticks, shift the filtered bit into the shift register at the MSB (LSB arrives first). After bit 7 → STOP (or PARITY when enabled).
  - STOP: after Oversampling ticks, sample the filtered bit.
    - 1: rx_data <= shift register and data_ready=1 for exactly one clk, on the clk after the sampling tick → IDLE.
    - 0: framing_error=1 for one clk, rx_data unchanged → BREAK.
  - BREAK: stay until filtered bit = 1 → IDLE. Line held low indefinitely produces exactly one framing_error.
- rx_busy is low only in IDLE.
- Latency: data_ready rises about 9.5 bit periods plus 3-4 ticks after the start edge.
- Back-to-back frames: a start edge arriving immediately after the stop-bit centre is accepted; there is no dead time beyond the filter delay.
- rst_n asserted mid-frame: everything returns to reset values immediately and the partial byte is discarded. After release, a frame in progress is received only if the line is seen high first. A low line after release enters START and normally ends in framing_error/BREAK.
- Accumulator wrap is intrinsic: the carry bit is dropped on the next add.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Frame becomes 8E1; a PARITY state sits between DATA and STOP.
  - Sampled parity must equal XOR of the 8 data bits. On mismatch, parity_error pulses one clk, coincident with the STOP-state outcome.
  - data_ready is suppressed on parity error; rx_data stays unchanged.
- Undefined: no PARITY state; parity_error is tied 0.

Test Plan:
- Send 0x55 (8N1, 460800 baud, 50 MHz clk, bit=108.5 clk) → one data_ready pulse, rx_data=0x55, framing_error=0, rx_busy high for about 1030 clk.
- Send 0x00 then 0xFF with zero inter-frame gap → two data_ready pulses about 1085 clk apart, values 0x00 then 0xFF.
- Drive rxd low for 10 clk (shorter than 1 tick) → no state change, rx_busy=0; low for 40 clk (shorter than half a bit) → rx_busy pulses, then returns to IDLE with no data_ready or framing_error.
- Send 0xA5 with stop bit forced 0, then hold low for 5 bit times → single framing_error, rx_data keeps its prior value, rx_busy stays high until the line goes high.
- Assert rst_n low for 3 clk at bit 4 of 0x3C, then send 0xC3 → all outputs 0 during reset; next data_ready carries 0xC3; the 0x3C byte is never delivered.
- With UART_RX_PARITY_EN: send 0x01 with parity bit 1 → data_ready with rx_data=0x01; send 0x01 with parity bit 0 → parity_error pulse and no data_ready.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver with its own fractional-accumulator oversampling tick, 2-flop synchroniser,
// 3-sample majority filter and centre sampling. Define UART_RX_PARITY_EN for 8E1 with parity_error.
module uart_rx_oversampled #(
    parameter int unsigned ClkFrequency = 50000000,
    parameter int unsigned Baud         = 460800,
    parameter int unsigned Oversampling = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       data_ready,
    output logic       framing_error,
    output logic       parity_error,
    output logic       rx_busy
);

    // Number of bits needed to hold v.
    function automatic int unsigned bit_len(input int unsigned v);
        int unsigned n;
        n = 0;
        while ((v >> n) != 0) n++;
        return n;
    endfunction

    localparam int unsigned AccWidth = bit_len(ClkFrequency / Baud) + 8;
    localparam int unsigned AccW1    = AccWidth + 1;
    // Pre-shifted rounding keeps every intermediate inside 32 bits.
    localparam int unsigned Inc      = ((Baud * Oversampling << (AccWidth - 7)) + (ClkFrequency >> 8))
                                       / (ClkFrequency >> 7);
    localparam int unsigned CntW     = $clog2(Oversampling);

    localparam logic [CntW-1:0]    HalfM1  = CntW'(Oversampling / 2 - 1);
    localparam logic [CntW-1:0]    LastCnt = CntW'(Oversampling - 1);
    localparam logic [AccWidth:0]  IncVal  = AccW1'(Inc);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    logic [AccWidth:0] r_acc;
    logic              w_tick;
    logic              r_sync1;
    logic              r_sync2;
    logic [2:0]        r_hist;
    logic              w_filt;
    state_t            r_state;
    logic [CntW-1:0]   r_cnt;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic [7:0]        r_rx_data;
    logic              r_data_ready;
    logic              r_framing_error;
    logic              r_busy;
`ifdef UART_RX_PARITY_EN
    logic              r_par;
    logic              r_parity_error;
    logic              w_par_ok;
`endif

    // Free-running tick generator; the carry out is the tick and is dropped on the next add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else begin
            r_acc <= {1'b0, r_acc[AccWidth-1:0]} + IncVal;
        end
    end

    assign w_tick = r_acc[AccWidth];

    // Metastability synchroniser and tick-rate majority history, both idling at the line-idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 3'b111;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
            if (w_tick) begin
                r_hist <= {r_hist[1:0], r_sync2};
            end
        end
    end

    assign w_filt = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);

`ifdef UART_RX_PARITY_EN
    assign w_par_ok = (r_par == ^r_shift);
`endif

    // Frame FSM; every transition happens on a tick, strobes are cleared on every other clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_bit           <= '0;
            r_shift         <= '0;
            r_rx_data       <= '0;
            r_data_ready    <= 1'b0;
            r_framing_error <= 1'b0;
            r_busy          <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par           <= 1'b0;
            r_parity_error  <= 1'b0;
`endif
        end else begin
            r_data_ready    <= 1'b0;
            r_framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_error  <= 1'b0;
`endif
            if (w_tick) begin
                r_cnt <= r_cnt + CntW'(1);
                case (r_state)
                    S_IDLE: begin
                        if (!w_filt) begin
                            r_state <= S_START;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (r_cnt == HalfM1) begin
                            r_cnt <= '0;
                            if (!w_filt) begin
                                r_state <= S_DATA;
                                r_bit   <= '0;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    S_DATA: begin
                        if (r_cnt == LastCnt) begin
                            r_shift <= {w_filt, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                            if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= S_PARITY;
`else
                                r_state <= S_STOP;
`endif
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (r_cnt == LastCnt) begin
                            r_par   <= w_filt;
                            r_state <= S_STOP;
                        end
                    end
`endif
                    S_STOP: begin
                        if (r_cnt == LastCnt) begin
`ifdef UART_RX_PARITY_EN
                            r_parity_error <= !w_par_ok;
`endif
                            if (w_filt) begin
`ifdef UART_RX_PARITY_EN
                                if (w_par_ok) begin
                                    r_rx_data    <= r_shift;
                                    r_data_ready <= 1'b1;
                                end
`else
                                r_rx_data    <= r_shift;
                                r_data_ready <= 1'b1;
`endif
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_framing_error <= 1'b1;
                                r_state         <= S_BREAK;
                            end
                        end
                    end
                    S_BREAK: begin
                        if (w_filt) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_data       = r_rx_data;
    assign data_ready    = r_data_ready;
    assign framing_error = r_framing_error;
    assign rx_busy       = r_busy;
`ifdef UART_RX_PARITY_EN
    assign parity_error  = r_parity_error;
`else
    assign parity_error  = 1'b0;
`endif

endmodule
